// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the carry-lookahead adder.
//   CLA_GROUP          bits per first-level lookahead group
//   CLA_DEFAULT_WIDTH  default operand width of cla_adder
//   cla_num_groups()   number of groups for a given operand width
package cla_pkg;

    localparam int unsigned CLA_GROUP         = 4;
    localparam int unsigned CLA_DEFAULT_WIDTH = 4;

    function automatic int unsigned cla_num_groups(input int unsigned width);
        return width / CLA_GROUP;
    endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: purely combinational 4-bit carry-lookahead unit.
//   p[3:0], g[3:0]  per-bit propagate / generate
//   cin             carry into bit 0 of the group
//   c[3:0]          carry into each bit (c[0] == cin)
//   GP, GG          group propagate / group generate for the second level
module cla_group (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [3:0] c,
    output logic       GP,
    output logic       GG
);

    // Every carry is a flattened sum of products, so no carry depends on
    // another carry inside the group.
    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        GP   = &p;
        GG   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/cla_adder.sv
// cla_adder: registered two-level carry-lookahead adder, {Cout,S} = A+B+Cin.
// Inputs are registered, the sum is registered: fixed 2-edge latency,
// one operation per clock.
//   clk   clock, rising edge
//   rst   asynchronous active-high reset, clears all registers
//   A, B  WIDTH-bit unsigned operands (WIDTH a positive multiple of 4)
//   Cin   carry in
//   S     registered sum
//   Cout  registered carry out
//   ovf   registered two's-complement overflow (only with CLA_OVF_EN)
module cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = CLA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NG = cla_num_groups(WIDTH);

    generate
        if (WIDTH == 0 || (WIDTH % CLA_GROUP) != 0) begin : g_bad_width
            $error("cla_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    logic [WIDTH-1:0] A1, B1;
    logic             Cin1;
    logic [WIDTH-1:0] p, g, c, S_next;
    logic [NG-1:0]    GG, GP;
    logic [NG:0]      gc;
    logic             acc, prod;
    logic             Cout_next;

    assign g = A1 & B1;
    assign p = A1 ^ B1;

    generate
        for (genvar k = 0; k < NG; k++) begin : g_grp
            cla_group u_grp (
                .p  (p[CLA_GROUP*k +: CLA_GROUP]),
                .g  (g[CLA_GROUP*k +: CLA_GROUP]),
                .cin(gc[k]),
                .c  (c[CLA_GROUP*k +: CLA_GROUP]),
                .GP (GP[k]),
                .GG (GG[k])
            );
        end
    endgenerate

    // Second-level lookahead: gc[k] is built as a flat OR of
    // GG[j]&GP[j+1..k-1] terms plus Cin1&GP[0..k-1], never from gc[k-1],
    // so the group carries do not ripple.
    always_comb begin
        gc    = '0;
        acc   = 1'b0;
        prod  = 1'b0;
        gc[0] = Cin1;
        for (int unsigned k = 1; k <= NG; k++) begin
            acc = 1'b0;
            for (int unsigned j = 0; j < k; j++) begin
                prod = GG[j];
                for (int unsigned m = j + 1; m < k; m++) begin
                    prod = prod & GP[m];
                end
                acc = acc | prod;
            end
            prod = Cin1;
            for (int unsigned m = 0; m < k; m++) begin
                prod = prod & GP[m];
            end
            gc[k] = acc | prod;
        end
    end

    assign S_next    = p ^ c;
    assign Cout_next = gc[NG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A1   <= '0;
            B1   <= '0;
            Cin1 <= 1'b0;
        end else begin
            A1   <= A;
            B1   <= B;
            Cin1 <= Cin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S    <= '0;
            Cout <= 1'b0;
        end else begin
            S    <= S_next;
            Cout <= Cout_next;
        end
    end

`ifdef CLA_OVF_EN
    // Overflow: carry out of the MSB differs from carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= gc[NG] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_cla_adder.sv
module tb_cla_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, s4;
    logic       ci4 = 1'b0, co4;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       ci8 = 1'b0, co8;
`ifdef CLA_OVF_EN
    logic       ov4, ov8;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(ci4), .S(s4), .Cout(co4)
`ifdef CLA_OVF_EN
        , .ovf(ov4)
`endif
    );

    cla_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(ci8), .S(s8), .Cout(co8)
`ifdef CLA_OVF_EN
        , .ovf(ov8)
`endif
    );

    typedef struct {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    // Reference: plain integer addition, overflow from signed range check.
    function automatic res_t ref_add(input int w, input logic [7:0] a,
                                     input logic [7:0] b, input logic cin);
        res_t r;
        int   sum, sa, sb, ss;
        sum    = int'(a) + int'(b) + int'(cin);
        r.s    = 8'(sum % (1 << w));
        r.cout = ((sum >> w) & 1) != 0;
        sa     = a[w-1] ? int'(a) - (1 << w) : int'(a);
        sb     = b[w-1] ? int'(b) - (1 << w) : int'(b);
        ss     = sa + sb + int'(cin);
        r.ovf  = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Two-deep delay line of reference results (inputs -> 2 edges -> outputs).
    res_t pend4, out4, pend8, out8;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend4 <= '{8'h00, 1'b0, 1'b0};
            out4  <= '{8'h00, 1'b0, 1'b0};
            pend8 <= '{8'h00, 1'b0, 1'b0};
            out8  <= '{8'h00, 1'b0, 1'b0};
        end else begin
            out4  <= pend4;
            pend4 <= ref_add(4, {4'h0, a4}, {4'h0, b4}, ci4);
            out8  <= pend8;
            pend8 <= ref_add(8, a8, b8, ci8);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model4_S", {4'h0, s4}, out4.s);
            check("model4_Cout", {7'h0, co4}, {7'h0, out4.cout});
            check("model8_S", s8, out8.s);
            check("model8_Cout", {7'h0, co8}, {7'h0, out8.cout});
`ifdef CLA_OVF_EN
            check("model4_ovf", {7'h0, ov4}, {7'h0, out4.ovf});
            check("model8_ovf", {7'h0, ov8}, {7'h0, out8.ovf});
`endif
        end
    end

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        tbl[2]  = '{4'b0101, 4'b1010, 1'b0, 4'b1111, 1'b0, 1'b0};
        tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{4'b1001, 4'b1001, 1'b1, 4'b0011, 1'b1, 1'b1};
        tbl[6]  = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        tbl[7]  = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[8]  = '{4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0};
        tbl[9]  = '{4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[10] = '{4'b0110, 4'b0011, 1'b1, 4'b1010, 1'b0, 1'b1};

        #1 rst = 1'b1;
        chk_en = 1'b1;
        #12;
        check("reset_S4", {4'h0, s4}, 8'h00);
        check("reset_Cout4", {7'h0, co4}, 8'h00);
        check("reset_S8", s8, 8'h00);

        // Release mid-cycle and hold 1001+1001+1 / FF+01+0.
        rst = 1'b0;
        a4 = 4'b1001; b4 = 4'b1001; ci4 = 1'b1;
        a8 = 8'hFF;   b8 = 8'h01;   ci8 = 1'b0;
        @(posedge clk); #1;
        check("first_edge_S4", {4'h0, s4}, 8'h00);
        check("first_edge_Cout4", {7'h0, co4}, 8'h00);
        check("first_edge_S8", s8, 8'h00);
        @(posedge clk); #1;
        check("second_edge_S4", {4'h0, s4}, 8'h03);
        check("second_edge_Cout4", {7'h0, co4}, 8'h01);
        check("w8_carry_S8", s8, 8'h00);
        check("w8_carry_Cout8", {7'h0, co8}, 8'h01);

        // Back-to-back table vectors.
        for (int i = 0; i <= 11; i++) begin
            if (i < 11) begin
                a4 = tbl[i].a; b4 = tbl[i].b; ci4 = tbl[i].cin;
            end else begin
                a4 = '0; b4 = '0; ci4 = 1'b0;
            end
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            @(posedge clk); #1;
            if (i >= 1) begin
                check("tbl_S", {4'h0, s4}, {4'h0, tbl[i-1].s});
                check("tbl_Cout", {7'h0, co4}, {7'h0, tbl[i-1].cout});
`ifdef CLA_OVF_EN
                check("tbl_ovf", {7'h0, ov4}, {7'h0, tbl[i-1].ovf});
`endif
            end
        end

        // Exhaustive 4-bit sweep, random 8-bit stream; checked by the model.
        for (int i = 0; i < 512; i++) begin
            {ci4, a4, b4} = 9'(i);
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            @(posedge clk); #1;
        end

        // Reset between edges while results are in flight.
        a4 = 4'b0111; b4 = 4'b0110; ci4 = 1'b1;
        a8 = 8'h5A;   b8 = 8'h3C;   ci8 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_S4", {4'h0, s4}, 8'h00);
        check("async_rst_Cout4", {7'h0, co4}, 8'h00);
        check("async_rst_S8", s8, 8'h00);
        check("async_rst_Cout8", {7'h0, co8}, 8'h00);
        @(negedge clk); #1;
        rst = 1'b0;
        a4 = 4'b1111; b4 = 4'b1111; ci4 = 1'b1;
        @(posedge clk); #1;
        check("restart_edge1_S4", {4'h0, s4}, 8'h00);
        check("restart_edge1_Cout4", {7'h0, co4}, 8'h00);
        @(posedge clk); #1;
        check("restart_edge2_S4", {4'h0, s4}, 8'h0F);
        check("restart_edge2_Cout4", {7'h0, co4}, 8'h01);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_adder.md
# cla_adder

Registered carry-lookahead adder. Computes A + B + Cin with a two-level carry-lookahead network. Inputs and outputs are both registered, so it drops into a synchronous datapath with fixed 2-cycle latency and one new operation accepted per clock.

## Interface
- WIDTH, 4: operand width. Must be a positive multiple of 4; any other value is an elaboration error.
- clk  input  1  clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry in.
- S  output  WIDTH  registered sum.
- Cout  output  1  registered carry out.
- ovf  output  1  registered signed overflow; present only with CLA_OVF_EN.

## Operation
- Stage 1, input registers: A1, B1, Cin1 capture A, B, Cin on every posedge. No enable and no handshake.
- Combinational core, per bit: g[i] = A1[i] & B1[i], p[i] = A1[i] ^ B1[i].
- Bits are split into 4-bit groups. Inside each group, carries use flattened lookahead equations, with no ripple. Example: c2 = g1 | p1&g0 | p1&p0&c0.
- Each group also produces group generate GG and group propagate GP.
- Group carry-ins come from a second-level lookahead over (GG, GP), seeded by Cin1.
- Sum bits: S_next[i] = p[i] ^ c[i]. Cout_next = carry out of the top group.
- Result: {Cout, S} = A1 + B1 + Cin1, exact, (WIDTH+1) bits. No wrap loss.
- Stage 2, output registers: S and Cout capture S_next and Cout_next on every posedge.
- Reset: while rst is high, A1, B1, Cin1, S, Cout (and ovf) are 0 immediately, without waiting for a clock edge.

## Timing
- Latency is 2 rising edges: inputs sampled at edge N appear on S/Cout after edge N+1.
- Throughput is 1 result per clock, back-to-back.
- Outputs are stable for the whole cycle after each edge. They never change combinationally with A, B or Cin.
- After rst deasserts:
  - The first edge loads the inputs, and outputs stay at the reset value 0.
  - The second edge presents the first valid result.
- Reset asserted mid-stream: in-flight operations are discarded and the pipeline restarts as above.
- Boundary cases:
  - All-propagate (A ^ B = all ones) with Cin = 1 carries across every group: S = 0, Cout = 1.
  - Max operands plus Cin gives S = all ones, Cout = 1.

## Configuration
- CLA_OVF_EN defined: adds output ovf.
  - ovf_next = c[WIDTH] ^ c[WIDTH-1], the two's-complement overflow of A1 + B1 + Cin1.
  - ovf is registered alongside S and has the same latency and the same reset value (0).
- CLA_OVF_EN undefined: ovf port and its logic are absent. Everything else is identical.

## Structure
- Shared package cla_pkg holds:
  - CLA_GROUP = 4 (group size),
  - CLA_DEFAULT_WIDTH = 4,
  - the function computing the number of groups (WIDTH / CLA_GROUP).
- Sub-module cla_group: pure combinational 4-bit lookahead unit.
  - Inputs: p[3:0], g[3:0], cin.
  - Outputs: c[3:0] (internal carries), GP, GG.
  - The top level instantiates it WIDTH/4 times in a generate loop.
  - The second-level lookahead and the registers stay in cla_adder.

## Test plan
- Reset, then A=1001, B=1001, Cin=1 held: S=0000/Cout=0 after the first edge; S=0011, Cout=1 after the second edge.
- A=1111, B=0000, Cin=1 (full propagate chain): S=0000, Cout=1 two edges later. A=0000, B=0000, Cin=0: S=0000, Cout=0.
- Back-to-back operands 0011+0100+0, 1111+1111+1, 0101+1010+0 on consecutive edges: S/Cout = 0111/0, 1111/1, 1111/0 on consecutive cycles starting 2 edges after the first.
- Assert rst between clock edges during a stream: S, Cout go to 0 immediately, with no edge needed. After release, the first valid result appears on the second edge.
- WIDTH=8: A=0xFF, B=0x01, Cin=0 gives S=0x00, Cout=1, exercising the inter-group carry. Exhaustive 4-bit sweep (512 cases) compared against a behavioral A+B+Cin model with 2-cycle delay.
- With CLA_OVF_EN: 0111+0001+0 gives ovf=1; 1000+1000+0 gives ovf=1 and Cout=1; 0011+0001+0 gives ovf=0.
